// File: rtl/big_add_arbiter.sv
// big_add_arbiter
//   Round-robin front end that lets NUM_REQ requesters share one wide adder.
//   One transaction is in flight at a time: the winner's operands are
//   registered and held for the adder, the adder result is captured, and it
//   is returned on a valid/ready response channel tagged with the winner id.
//
// Parameters
//   WIDTH    operand/result width (matches the shared adder's Size_add)
//   NUM_REQ  number of requesters (>= 2)
//   TIMEOUT  BUSY watchdog limit in cycles, used only when the build macro
//            BIG_ADD_ARB_TIMEOUT_EN is defined
//
// Ports
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   req                per-requester request level
//   req_a, req_b       per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   gnt                one-hot, one-cycle acceptance pulse
//   rsp_valid/ready    response handshake
//   rsp_id, rsp_c      winner id and sum
//   rsp_err            1 = watchdog expired (always 0 without the macro)
//   add_en/a/b         adder start pulse and held operands
//   add_done, add_c    adder completion pulse and sum
//
// Build option
//   BIG_ADD_ARB_TIMEOUT_EN  when defined, a BUSY cycle counter forces an
//                           error response after TIMEOUT cycles.

module big_add_arbiter #(
  parameter int WIDTH   = 3328,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_c,
  output logic                       rsp_err,
  output logic                       add_en,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic                       add_done,
  input  logic [WIDTH-1:0]           add_c
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic              r_add_en, w_add_en_next;
  logic [WIDTH-1:0]  r_add_a, w_add_a_next;
  logic [WIDTH-1:0]  r_add_b, w_add_b_next;
  logic [ID_W-1:0]   r_rsp_id, w_rsp_id_next;
  logic [WIDTH-1:0]  r_rsp_c, w_rsp_c_next;
  logic              r_rsp_valid, w_rsp_valid_next;

`ifdef BIG_ADD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic              r_rsp_err, w_rsp_err_next;
  logic [CNT_W-1:0]  r_to_cnt, w_to_cnt_next, w_to_cnt_inc;
`endif

  // Per-requester operand views
  logic [WIDTH-1:0] w_op_a [NUM_REQ];
  logic [WIDTH-1:0] w_op_b [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_op_a[gi] = req_a[gi*WIDTH +: WIDTH];
      assign w_op_b[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: first set request at or after the pointer, wrapping.
  logic            w_found;
  logic [ID_W-1:0] w_sel;
  int              w_idx;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = ID_W'(w_idx);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_gnt_next       = '0;
    w_add_en_next    = 1'b0;
    w_add_a_next     = r_add_a;
    w_add_b_next     = r_add_b;
    w_rsp_id_next    = r_rsp_id;
    w_rsp_c_next     = r_rsp_c;
    w_rsp_valid_next = r_rsp_valid;
`ifdef BIG_ADD_ARB_TIMEOUT_EN
    w_rsp_err_next   = r_rsp_err;
    w_to_cnt_inc     = r_to_cnt + 1'b1;
    w_to_cnt_next    = r_to_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_next        = '0;
          w_gnt_next[w_sel] = 1'b1;
          w_add_en_next     = 1'b1;
          w_add_a_next      = w_op_a[w_sel];
          w_add_b_next      = w_op_b[w_sel];
          w_rsp_id_next     = w_sel;
          w_state_next      = S_BUSY;
        end
      end

      // Operands stay untouched here: the adder samples them on two
      // consecutive cycles after the start pulse.
      S_BUSY: begin
        if (add_done) begin
          w_rsp_c_next     = add_c;
          w_rsp_valid_next = 1'b1;
          w_state_next     = S_RESP;
`ifdef BIG_ADD_ARB_TIMEOUT_EN
          w_rsp_err_next   = 1'b0;
          w_to_cnt_next    = '0;
`endif
        end
`ifdef BIG_ADD_ARB_TIMEOUT_EN
        else if (w_to_cnt_inc == CNT_W'(TIMEOUT)) begin
          w_rsp_c_next     = '0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
          w_to_cnt_next    = '0;
          w_state_next     = S_RESP;
        end else begin
          w_to_cnt_next    = w_to_cnt_inc;
        end
`endif
      end

      // Response held until accepted; no grant on the handshake edge.
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_next = 1'b0;
          w_rr_ptr_next    = ID_W'((int'(r_rsp_id) + 1) % NUM_REQ);
          w_state_next     = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_add_en    <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_rsp_id    <= '0;
      r_rsp_c     <= '0;
      r_rsp_valid <= 1'b0;
`ifdef BIG_ADD_ARB_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
      r_to_cnt    <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_gnt       <= w_gnt_next;
      r_add_en    <= w_add_en_next;
      r_add_a     <= w_add_a_next;
      r_add_b     <= w_add_b_next;
      r_rsp_id    <= w_rsp_id_next;
      r_rsp_c     <= w_rsp_c_next;
      r_rsp_valid <= w_rsp_valid_next;
`ifdef BIG_ADD_ARB_TIMEOUT_EN
      r_rsp_err   <= w_rsp_err_next;
      r_to_cnt    <= w_to_cnt_next;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign add_en    = r_add_en;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_c     = r_rsp_c;
`ifdef BIG_ADD_ARB_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
